// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x oversampled UART receiver driven by the RX baud divider square waves.
module uart_rx_core #(
    parameter int DATA_BITS = 8,
    parameter int OVS       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 T1200,
    input  logic                 T2400,
    input  logic                 T4800,
    input  logic                 T9600,
    input  logic [1:0]           baud_sel,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(OVS);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_MID  = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic                 rx_s1, rx_s;
    logic [1:0]           sel_q, sel_eff;
    logic                 wave, wave_q, wave_prev, tick;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;

    // The rate is frozen for the whole frame once the start bit has been seen.
    assign sel_eff = (state == IDLE) ? baud_sel : sel_q;

    always_comb begin
        wave = T1200;
        case (sel_eff)
            2'd0:    wave = T1200;
            2'd1:    wave = T2400;
            2'd2:    wave = T4800;
            default: wave = T9600;
        endcase
    end

    assign tick = wave_q & ~wave_prev;
    assign busy = (state != IDLE);

    always_comb begin
        state_n = state;
        if (tick) begin
            case (state)
                IDLE:    if (!rx_s) state_n = START;
                START:   if (cnt == CNT_MID) state_n = rx_s ? IDLE : DATA;
                DATA:    if (cnt == CNT_LAST && bit_idx == LAST_BIT)
                             state_n = parity_en ? PARITY : STOP;
                PARITY:  if (cnt == CNT_LAST) state_n = STOP;
                STOP:    if (cnt == CNT_LAST) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rx_s1      <= 1'b1;
            rx_s       <= 1'b1;
            wave_q     <= 1'b1;
            wave_prev  <= 1'b1;
            sel_q      <= '0;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state     <= state_n;
            rx_s1     <= rx;
            rx_s      <= rx_s1;
            wave_q    <= wave;
            wave_prev <= wave_q;
            rx_valid  <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        perr    <= 1'b0;
                        if (!rx_s) sel_q <= baud_sel;
                    end
                    START: cnt <= (cnt == CNT_MID) ? '0 : cnt + 1'b1;
                    DATA: begin
                        // cnt wraps naturally, so each bit is sampled 16 ticks after the last.
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    PARITY: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) perr <= (^shreg) ^ rx_s ^ parity_odd;
                    end
                    STOP: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            rx_data    <= shreg;
                            frame_err  <= ~rx_s;
                            parity_err <= perr;
                            rx_valid   <= 1'b1;
                        end
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed self-checking bench for uart_rx_core.
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] div = '0;
    logic       T1200, T2400, T4800, T9600;
    logic [1:0] baud_sel;
    logic       parity_en, parity_odd, rx;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, busy;

    int n_assert = 0;
    int n_fail   = 0;
    int vcnt     = 0;
    int exp_v    = 0;
    logic busy_q1, busy_q3;

    uart_rx_core dut (
        .clk        (clk),
        .rst        (rst),
        .T1200      (T1200),
        .T2400      (T2400),
        .T4800      (T4800),
        .T9600      (T9600),
        .baud_sel   (baud_sel),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    // Scaled-down divider: periods 32/16/8/4 clk keep the 2:1 ratios; bit time = 16 * period.
    always @(posedge clk) div <= div + 5'd1;
    assign T9600 = div[1];
    assign T4800 = div[2];
    assign T2400 = div[3];
    assign T1200 = div[4];

    always @(negedge clk) if (rx_valid) vcnt = vcnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit pen, input bit pbit, input bit stop,
                        input int bt, input bit chg);
        logic [1:0] orig;
        orig = baud_sel;
        rx = 1'b0;
        repeat (bt) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (chg && i == 3) baud_sel = 2'd0;
            repeat (bt) @(negedge clk);
        end
        if (pen) begin
            rx = pbit;
            repeat (bt) @(negedge clk);
        end
        rx = stop;
        repeat (bt / 4) @(negedge clk);
        busy_q1 = busy;
        if (chg) baud_sel = orig;
        repeat (bt / 2) @(negedge clk);
        busy_q3 = busy;
        rx = 1'b1;
        repeat (bt - bt / 4 - bt / 2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; baud_sel = 2'd3; parity_en = 1'b0; parity_odd = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_valid", rx_valid, 1'b0);
        chk("reset_perr", parity_err, 1'b0);
        chk("reset_ferr", frame_err, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // 9600, no parity, 0xA5
        send(8'hA5, 0, 0, 1, 64, 0); exp_v++;
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_vcnt", vcnt, exp_v);
        chk("a5_perr", parity_err, 1'b0);
        chk("a5_ferr", frame_err, 1'b0);
        chk("a5_busy_early_stop", busy_q1, 1'b1);
        chk("a5_busy_late_stop", busy_q3, 1'b0);
        repeat (64) @(negedge clk);

        // 1200, even parity
        baud_sel = 2'd0; parity_en = 1'b1; parity_odd = 1'b0;
        send(8'h3C, 1, 0, 1, 512, 0); exp_v++;
        chk("3c_good_data", rx_data, 8'h3C);
        chk("3c_good_perr", parity_err, 1'b0);
        chk("3c_good_vcnt", vcnt, exp_v);
        repeat (512) @(negedge clk);
        send(8'h3C, 1, 1, 1, 512, 0); exp_v++;
        chk("3c_bad_data", rx_data, 8'h3C);
        chk("3c_bad_perr", parity_err, 1'b1);
        chk("3c_bad_ferr", frame_err, 1'b0);
        chk("3c_bad_vcnt", vcnt, exp_v);
        repeat (256) @(negedge clk);

        // 2400, odd parity, parity bit 1 on four ones is correct
        baud_sel = 2'd1; parity_odd = 1'b1;
        send(8'h3C, 1, 1, 1, 256, 0); exp_v++;
        chk("3c_odd_perr", parity_err, 1'b0);
        chk("3c_odd_vcnt", vcnt, exp_v);
        repeat (256) @(negedge clk);

        // Glitch of 4 ticks at 9600: false start rejected at tick 7
        baud_sel = 2'd3; parity_en = 1'b0; parity_odd = 1'b0;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("glitch_busy_20", busy, 1'b1);
        repeat (10) @(negedge clk);
        chk("glitch_busy_30", busy, 1'b1);
        repeat (10) @(negedge clk);
        chk("glitch_busy_40", busy, 1'b0);
        repeat (60) @(negedge clk);
        chk("glitch_vcnt", vcnt, exp_v);

        // 4800 back-to-back; first frame sees baud_sel changed mid-frame
        baud_sel = 2'd2;
        send(8'h00, 0, 0, 1, 128, 1); exp_v++;
        chk("b2b_00_data", rx_data, 8'h00);
        chk("b2b_00_vcnt", vcnt, exp_v);
        send(8'hFF, 0, 0, 1, 128, 0); exp_v++;
        chk("b2b_ff_data", rx_data, 8'hFF);
        chk("b2b_ff_vcnt", vcnt, exp_v);
        chk("b2b_ff_perr", parity_err, 1'b0);
        chk("b2b_ff_ferr", frame_err, 1'b0);
        repeat (128) @(negedge clk);

        // 2400, stop low plus wrong even parity on 0x81
        baud_sel = 2'd1; parity_en = 1'b1; parity_odd = 1'b0;
        send(8'h81, 1, 1, 0, 256, 0); exp_v++;
        chk("81_data", rx_data, 8'h81);
        chk("81_ferr", frame_err, 1'b1);
        chk("81_perr", parity_err, 1'b1);
        chk("81_vcnt", vcnt, exp_v);
        repeat (512) @(negedge clk);
        chk("81_after_busy", busy, 1'b0);
        chk("81_after_vcnt", vcnt, exp_v);

        // Reset in the middle of DATA
        baud_sel = 2'd3; parity_en = 1'b0;
        rx = 1'b0; repeat (64) @(negedge clk);
        rx = 1'b1; repeat (64) @(negedge clk);
        rx = 1'b0; repeat (64) @(negedge clk);
        rx = 1'b1; repeat (32) @(negedge clk);
        chk("mid_data_busy", busy, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_data", rx_data, 8'h00);
        chk("rst_mid_perr", parity_err, 1'b0);
        chk("rst_mid_ferr", frame_err, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_valid", rx_valid, 1'b0);
        repeat (640) @(negedge clk);
        chk("rst_mid_vcnt", vcnt, exp_v);
        send(8'h55, 0, 0, 1, 64, 0); exp_v++;
        chk("55_data", rx_data, 8'h55);
        chk("55_vcnt", vcnt, exp_v);
        chk("55_ferr", frame_err, 1'b0);
        chk("55_perr", parity_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receiver that consumes the four oversampling square waves produced by the RX baud divider (16× of 1200/2400/4800/9600 baud) and turns the asynchronous `rx` line into bytes. It selects one oversampling clock and converts its rising edges into one-cycle sample enables. A 16× oversampled state machine finds the start bit, samples each bit at mid-bit, and delivers an 8-bit word with parity and framing status to the downstream byte consumer.

## Interface
- `DATA_BITS`, 8, data bits per frame, sent LSB first.
- `OVS`, 16, oversampling ratio; must match the divider outputs.
- `clk` in 1: system clock, 50 MHz (20 ns period).
- `rst` in 1: synchronous, active-high reset.
- `T1200`, `T2400`, `T4800`, `T9600` in 1 each: divider square waves at 19200, 38400, 76800 and 153600 Hz.
- `baud_sel` in 2: 0 = T1200, 1 = T2400, 2 = T4800, 3 = T9600.
- `parity_en` in 1: a parity bit follows the data bits.
- `parity_odd` in 1: 1 = odd parity, 0 = even parity.
- `rx` in 1: asynchronous serial line, idle high.
- `rx_data` out 8: last received byte.
- `rx_valid` out 1: one-cycle strobe when a frame completes.
- `parity_err` out 1: parity mismatch on the last frame.
- `frame_err` out 1: stop bit sampled low on the last frame.
- `busy` out 1: high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1.
- **Baud selection:** `baud_sel` is latched into `sel_q` when the start bit is detected. Changes to `baud_sel` during a frame are ignored until IDLE.
- **Tick generation:** the edge detector reads the muxed wave (`baud_sel` in IDLE, `sel_q` otherwise). Its previous-value register resets to 1, so no tick is produced at reset. `tick` pulses for one cycle on each 0→1 transition.
- All state and counter updates happen only on `tick` cycles. `cnt` is 4 bits and `bit_idx` is 3 bits.
- **IDLE:** if synchronized `rx` == 0 → START, `cnt` = 0.
- **START:** at `cnt` == 7 (mid start bit):
  - `rx` == 1 → false start, go to IDLE with no output.
  - otherwise `cnt` = 0 and go to DATA.
- **DATA:** at `cnt` == 15, shift `rx` into the shift register MSB-side, so the first bit received ends at bit 0. After bit 7 → PARITY if `parity_en`, else STOP. `cnt` wraps to 0 on each bit.
- **PARITY:** at `cnt` == 15, compute `perr` = (XOR of data bits ^ rx ^ parity_odd). → STOP.
- **STOP:** at `cnt` == 15:
  - `rx_data` ← shift register.
  - `frame_err` ← ~rx.
  - `parity_err` ← `perr` (0 if parity disabled).
  - `rx_valid` = 1 for that cycle; go to IDLE.
- IDLE is re-entered at mid stop bit, so a back-to-back start edge is still caught.
- A frame completes and `rx_valid` fires even when an error is flagged. Data is delivered regardless.
- `rx_data`, `parity_err` and `frame_err` hold until the next completed frame.

## Timing
- Reset values:
  - `rx_data` = 0x00; `rx_valid`, `parity_err`, `frame_err`, `busy` = 0.
  - State = IDLE; `cnt` and `bit_idx` = 0.
- Reset mid-frame aborts the frame with no `rx_valid`; outputs return to their reset values.
- `tick` pulses in the cycle after the rising edge of the selected wave is registered.
- Start detection latency is ≤ 1 tick after the falling edge reaches the synchronizer output. Add 2 clk of synchronizer delay.
- Sample points land at 8 + 16·k ticks after start detection, k = 1..8 for data, 9 for parity.
- Stop is sampled at k = 9 without parity, 10 with parity.
- `rx_valid` is registered and asserts on the cycle after the stop-sample tick, for exactly 1 clk.
- At 9600 baud: 1 bit ≈ 5208 clk, and `rx_valid` arrives ≈ 9.5 bit times after the start edge (no parity).
- Boundary case: a `tick` in the same cycle as `rst` is ignored, because reset wins.

## Test plan
- `baud_sel`=3, no parity, send 0xA5 with stop = 1 → `rx_data`=0xA5, one `rx_valid` pulse, both errors 0, and `busy` drops at mid stop bit.
- `baud_sel`=0, even parity, send 0x3C with parity bit 0 → `parity_err`=0. Resend with parity bit 1 → `parity_err`=1 and `rx_data`=0x3C.
- Stop bit driven low for 0x81 → `frame_err`=1, `rx_valid` still pulses, `rx_data`=0x81.
- Glitch: `rx` low for 4 ticks then high → back to IDLE at tick 7, with no `rx_valid` and `busy` low afterwards.
- Back-to-back 0x00 then 0xFF at 4800 baud with zero idle gap → two `rx_valid` pulses, data correct, no errors. Change `baud_sel` mid-frame → the current frame still decodes at the latched rate.
- Assert `rst` during DATA → no `rx_valid`, all outputs return to their reset values. A following 0x55 frame is received correctly.
